ceespu_memory: RTL and testbench
================================

Name: ceespu_memory

Overview:
- Memory-stage responder for the execute stage's data-memory request interface: address, enable, 4-bit byte write enables, lane-replicated store data, and selMem.
- Owns a synchronous word-wide data RAM.
- Stores commit in the request cycle.
- Loads stall the pipeline for a fixed number of wait cycles, then return lane-extracted, sign- or zero-extended data to writeback, with the register-write controls pipelined alongside.

Parameters:
- ADDR_W, 12, word-address width; RAM depth 2**ADDR_W words of 32 bits.
- WAIT_CYCLES, 1, extra load latency cycles (0..7); 0 means the load is ready the next cycle.

Ports:
- I_clk  in  1  clock, all state on rising edge
- I_rst  in  1  reset, asynchronous, active-high
- I_memE  in  1  access request this cycle
- I_memWe  in  4  byte write enables; nonzero = store, zero = load
- I_address  in  32  byte address; bits [ADDR_W+1:2] index the RAM, higher bits ignored
- I_storeData  in  32  lane-replicated store data
- I_selMem  in  3  [1:0]: 0=word, 1=half, 2=byte, 3=word; [2]: 1=zero-extend, 0=sign-extend
- I_we  in  1  register writeback enable from execute
- I_regD  in  5  destination register
- I_selWb  in  2  writeback source select, passed through
- I_aluResult  in  32  ALU result, passed through
- O_busy  out  1  stall request to upstream stages
- O_loadData  out  32  extracted and extended load data
- O_aluResult  out  32  registered pass-through
- O_we  out  1  registered writeback enable
- O_regD  out  5  registered destination register
- O_selWb  out  2  registered writeback source select
- O_misaligned  out  1  misalignment flag; present only with the optional feature

Behaviour:
- Reset (async): FSM=IDLE, wait counter=0, all outputs 0. RAM contents are not cleared.
- FSM states: IDLE, LOAD_WAIT, LOAD_DONE.
- IDLE, store (I_memE && I_memWe!=0):
  - each RAM byte i with I_memWe[i]=1 takes I_storeData[8i+7:8i] at the edge;
  - no stall; state stays IDLE.
- IDLE, load (I_memE && I_memWe==0):
  - capture word index, selMem, addr[1:0], regD, selWb, we into request registers;
  - O_busy rises combinationally in the request cycle;
  - if WAIT_CYCLES=0, go to LOAD_DONE; else go to LOAD_WAIT with counter=WAIT_CYCLES-1.
- LOAD_WAIT: O_busy=1; counter decrements each cycle; at 0, go to LOAD_DONE.
- LOAD_DONE:
  - O_busy=0; the RAM read word is valid;
  - O_loadData is registered from the extracted word at this edge;
  - O_we/O_regD/O_selWb are loaded from the request registers; return to IDLE.
- Total load latency: O_loadData valid WAIT_CYCLES+2 edges after the request edge.
- Upstream holds its inputs stable while O_busy=1; inputs are ignored in LOAD_WAIT and LOAD_DONE.
- Load extraction:
  - byte: lane = addr[1:0];
  - half: upper half if addr[0]=1, lower half otherwise (same lane rule as the store byte enables 4'b1100/4'b0011);
  - word: whole word;
  - extension to 32 bits per selMem[2].
- O_we: registered I_we && !O_busy, so a stalled cycle never writes back twice.
- O_aluResult and O_selWb update every non-stalled cycle.
- I_memE=0: no RAM write; pass-through registers still update.
- Reset mid-load: FSM returns to IDLE immediately, O_busy drops, the pending load is discarded, O_we=0.

Optional Feature:
- Macro CEESPU_MISALIGN_TRAP_EN.
- Defined:
  - a word access with addr[1:0]!=0 is misaligned; O_misaligned pulses 1 for one cycle (registered);
  - a misaligned store writes nothing;
  - a misaligned load completes with O_loadData=0 and O_we=0.
- Undefined: no check; the port is absent; the word index ignores addr[1:0].

Decomposition:
- Shared package ceespu_pkg: selMem size codes (MEM_WORD=0, MEM_HALF=1, MEM_BYTE=2), zero-extend bit index, FSM state typedef.
- Sub-module ceespu_load_align: combinational lane select and extension (word, addr[1:0], selMem → 32-bit result).

Test Plan:
- Store word 0xDEADBEEF to addr 0x10 (memWe=1111), then load word, WAIT_CYCLES=1 -> O_busy high for 2 cycles; O_loadData=0xDEADBEEF at edge 3; O_we=1, O_regD echoed.
- Store byte 0x80 (data 0x80808080, memWe=0100) at 0x22 -> signed byte load 0x22 gives 0xFFFFFF80; selMem=3'b110 gives 0x00000080; other bytes of the word unchanged.
- Store half 0x1234 with memWe=1100 at addr 0x31 -> half load at 0x31 gives 0x00001234; half load at 0x30 returns the untouched lower half.
- Back-to-back store then load with WAIT_CYCLES=0 -> store not stalled; load O_busy for exactly 1 cycle; data valid 2 edges after the request.
- Assert I_rst during LOAD_WAIT -> O_busy=0 and all outputs 0 immediately; no writeback pulse after reset release.
- With CEESPU_MISALIGN_TRAP_EN, word store at 0x42 -> O_misaligned=1 for one cycle; a later word load from 0x40 shows the RAM unchanged.

Source files
------------

// File: rtl/ceespu_pkg.sv
// ceespu_pkg: memory-stage access size codes, extension bit index and FSM state type
package ceespu_pkg;
   localparam logic [1:0] MEM_WORD = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_BYTE = 2'd2;
   localparam int ZEXT_BIT = 2;
   typedef enum logic [1:0] {IDLE, LOAD_WAIT, LOAD_DONE} state_t;
endpackage

// File: rtl/ceespu_load_align.sv
// ceespu_load_align: picks the addressed byte/half/word lane and sign- or zero-extends it
module ceespu_load_align
   import ceespu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  sel,
   output logic [31:0] result
);
   logic [7:0]  b;
   logic [15:0] h;
   logic        s;
   always_comb begin
      b = word[{addr_lo, 3'b000} +: 8];
      h = addr_lo[0] ? word[31:16] : word[15:0];
      s = ~sel[ZEXT_BIT];
      result = (sel[1:0] == MEM_BYTE) ? {{24{s & b[7]}}, b} :
               (sel[1:0] == MEM_HALF) ? {{16{s & h[15]}}, h} : word;
   end
endmodule

// File: rtl/ceespu_memory.sv
// ceespu_memory: memory stage with byte-enable data RAM and stalling loads
// Optional misaligned word-access trap enabled by CEESPU_MISALIGN_TRAP_EN.
module ceespu_memory
   import ceespu_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_memE,
   input  logic [3:0]  I_memWe,
   input  logic [31:0] I_address,
   input  logic [31:0] I_storeData,
   input  logic [2:0]  I_selMem,
   input  logic        I_we,
   input  logic [4:0]  I_regD,
   input  logic [1:0]  I_selWb,
   input  logic [31:0] I_aluResult,
   output logic        O_busy,
   output logic [31:0] O_loadData,
   output logic [31:0] O_aluResult,
   output logic        O_we,
   output logic [4:0]  O_regD,
`ifdef CEESPU_MISALIGN_TRAP_EN
   output logic        O_misaligned,
`endif
   output logic [1:0]  O_selWb
);
   localparam logic [2:0] CNT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

   logic [31:0]       mem [2**ADDR_W];
   logic [31:0]       rd_word, aligned;
   logic [ADDR_W-1:0] idx, req_idx;
   logic [2:0]        req_sel, cnt;
   logic [1:0]        req_lo, req_selWb;
   logic [4:0]        req_regD;
   logic              req_we, req_mis, mis, is_load, is_store;
   logic              unused;
   state_t            state, state_nx;

   assign idx = I_address[ADDR_W+1:2];
   assign unused = ^I_address[31:ADDR_W+2];
`ifdef CEESPU_MISALIGN_TRAP_EN
   assign mis = I_memE && I_selMem[1:0] != MEM_HALF && I_selMem[1:0] != MEM_BYTE && I_address[1:0] != 2'd0;
`else
   assign mis = 1'b0;
`endif
   assign is_load  = state == IDLE && I_memE && I_memWe == 4'd0;
   assign is_store = state == IDLE && I_memE && I_memWe != 4'd0 && !mis;

   always_ff @(posedge I_clk or posedge I_rst)
      if (I_rst) state <= IDLE;
      else       state <= state_nx;

   // Reset gates the request-cycle stall so a held load cannot stall during reset
   always_comb begin
      state_nx = state;
      O_busy   = 1'b0;
      if (is_load) begin
         O_busy   = !I_rst;
         state_nx = (WAIT_CYCLES == 0) ? LOAD_DONE : LOAD_WAIT;
      end else if (state == LOAD_WAIT) begin
         O_busy   = 1'b1;
         state_nx = (cnt == 3'd0) ? LOAD_DONE : LOAD_WAIT;
      end else if (state == LOAD_DONE) begin
         state_nx = IDLE;
      end
   end

   always_ff @(posedge I_clk) begin
      for (int i = 0; i < 4; i++)
         if (is_store && I_memWe[i]) mem[idx][8*i +: 8] <= I_storeData[8*i +: 8];
      rd_word <= mem[(state == IDLE) ? idx : req_idx];
   end

   ceespu_load_align u_align (
      .word    (rd_word),
      .addr_lo (req_lo),
      .sel     (req_sel),
      .result  (aligned)
   );

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         O_loadData  <= '0;
         O_aluResult <= '0;
         O_we        <= 1'b0;
         O_regD      <= '0;
         O_selWb     <= '0;
         req_idx     <= '0;
         req_sel     <= '0;
         req_lo      <= '0;
         req_regD    <= '0;
         req_selWb   <= '0;
         req_we      <= 1'b0;
         req_mis     <= 1'b0;
         cnt         <= '0;
      end else begin
         if (state == LOAD_DONE) begin
            O_loadData  <= req_mis ? 32'd0 : aligned;
            O_we        <= req_we & ~req_mis;
            O_regD      <= req_regD;
            O_selWb     <= req_selWb;
            O_aluResult <= I_aluResult;
         end else if (O_busy) begin
            O_we <= 1'b0;
         end else begin
            O_we        <= I_we;
            O_regD      <= I_regD;
            O_selWb     <= I_selWb;
            O_aluResult <= I_aluResult;
         end
         if (is_load) begin
            req_idx   <= idx;
            req_sel   <= I_selMem;
            req_lo    <= I_address[1:0];
            req_regD  <= I_regD;
            req_selWb <= I_selWb;
            req_we    <= I_we;
            req_mis   <= mis;
            cnt       <= CNT_INIT;
         end else if (state == LOAD_WAIT) begin
            cnt <= cnt - 3'd1;
         end
      end
   end

`ifdef CEESPU_MISALIGN_TRAP_EN
   always_ff @(posedge I_clk or posedge I_rst)
      if (I_rst) O_misaligned <= 1'b0;
      else       O_misaligned <= mis && state == IDLE;
`endif
endmodule

// File: tb/tb_ceespu_memory.sv
// tb_ceespu_memory: randomized scoreboard bench for ceespu_memory against a byte-array model
module tb_ceespu_memory;
   localparam int AW   = 6;
   localparam int WAIT = 1;
   localparam int NW   = 1 << AW;

   logic        I_clk = 0, I_rst = 1, I_memE = 0, I_we = 0;
   logic [3:0]  I_memWe = 0;
   logic [31:0] I_address = 0, I_storeData = 0, I_aluResult = 0;
   logic [2:0]  I_selMem = 0;
   logic [4:0]  I_regD = 0;
   logic [1:0]  I_selWb = 0;
   logic        O_busy, O_we;
   logic [31:0] O_loadData, O_aluResult;
   logic [4:0]  O_regD;
   logic [1:0]  O_selWb;
`ifdef CEESPU_MISALIGN_TRAP_EN
   logic        O_misaligned;
`endif

   ceespu_memory #(.ADDR_W(AW), .WAIT_CYCLES(WAIT)) dut (
      .I_clk(I_clk), .I_rst(I_rst), .I_memE(I_memE), .I_memWe(I_memWe),
      .I_address(I_address), .I_storeData(I_storeData), .I_selMem(I_selMem),
      .I_we(I_we), .I_regD(I_regD), .I_selWb(I_selWb), .I_aluResult(I_aluResult),
      .O_busy(O_busy), .O_loadData(O_loadData), .O_aluResult(O_aluResult),
      .O_we(O_we), .O_regD(O_regD),
`ifdef CEESPU_MISALIGN_TRAP_EN
      .O_misaligned(O_misaligned),
`endif
      .O_selWb(O_selWb)
   );

   always #5 I_clk = ~I_clk;

   typedef struct {
      logic [4:0]  regD;
      logic [1:0]  selWb;
      logic [31:0] alu;
      logic [31:0] data;
      bit          is_load;
      int          due;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] ref_mem [NW*4];
   int         checks = 0, errors = 0, cyc = 0;

   always @(posedge I_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge I_clk) begin
      exp_t e;
      if (!I_rst && O_we) begin
         if (sb.size() == 0) chk("unexpected_we", 32'(O_we), 32'd0);
         else begin
            e = sb.pop_front();
            chk("wb_cycle", cyc, e.due);
            chk("wb_regD", 32'(O_regD), 32'(e.regD));
            chk("wb_selWb", 32'(O_selWb), 32'(e.selWb));
            chk("wb_alu", O_aluResult, e.alu);
            if (e.is_load) chk("load_data", O_loadData, e.data);
         end
      end
   end

   function automatic bit is_mis(input logic [31:0] addr, input logic [2:0] sel);
`ifdef CEESPU_MISALIGN_TRAP_EN
      return sel[1:0] != 2'd1 && sel[1:0] != 2'd2 && addr[1:0] != 2'd0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] sel);
      int base = int'(addr[7:2]) * 4;
      int lo   = int'(addr[1:0]);
      int v;
      if (sel[1:0] == 2'd2) begin
         v = ref_mem[base + lo];
         if (!sel[2] && v > 127) v -= 256;
      end else if (sel[1:0] == 2'd1) begin
         v = (lo % 2 == 1) ? ref_mem[base+2] + 256 * ref_mem[base+3] : ref_mem[base] + 256 * ref_mem[base+1];
         if (!sel[2] && v > 32767) v -= 65536;
      end else begin
         return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
      end
      return 32'(v);
   endfunction

   task automatic step();
      @(posedge I_clk);
      #1;
   endtask

   task automatic set_common();
      I_aluResult = $urandom;
      I_regD      = 5'($urandom);
      I_selWb     = 2'($urandom);
   endtask

   task automatic push_wb(input bit is_load, input logic [31:0] data, input int lat);
      exp_t e;
      e.regD = I_regD; e.selWb = I_selWb; e.alu = I_aluResult;
      e.data = data; e.is_load = is_load; e.due = cyc + lat;
      sb.push_back(e);
   endtask

   task automatic nop(input bit we);
      I_memE = 0; I_memWe = 4'($urandom); I_storeData = $urandom;
      I_address = $urandom; I_selMem = 3'($urandom); I_we = we;
      set_common();
      if (we) push_wb(0, 0, 1);
      #1 chk("busy_nop", 32'(O_busy), 32'd0);
      step();
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [2:0] sel, input logic [3:0] mask, input logic [31:0] data);
      bit mis = is_mis(addr, sel);
      I_memE = 1; I_memWe = mask; I_address = addr; I_storeData = data;
      I_selMem = sel; I_we = 1'($urandom);
      set_common();
      if (I_we) push_wb(0, 0, 1);
      if (!mis)
         for (int i = 0; i < 4; i++)
            if (mask[i]) ref_mem[int'(addr[7:2]) * 4 + i] = data[8*i +: 8];
      #1 chk("busy_store", 32'(O_busy), 32'd0);
      step();
`ifdef CEESPU_MISALIGN_TRAP_EN
      chk("misaligned_store", 32'(O_misaligned), 32'(mis));
`endif
   endtask

   task automatic rand_store(input logic [31:0] addr);
      int         sz = $urandom_range(0, 3);
      logic [3:0] mask;
      logic [31:0] data;
      logic [7:0] b = 8'($urandom);
      logic [15:0] h = 16'($urandom);
      mask = (sz == 2) ? 4'b0001 << addr[1:0] : (sz == 1) ? (addr[0] ? 4'b1100 : 4'b0011) : 4'b1111;
      data = (sz == 2) ? {4{b}} : (sz == 1) ? {2{h}} : $urandom;
      do_store(addr, {1'($urandom), 2'(sz)}, mask, data);
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [2:0] sel);
      bit mis = is_mis(addr, sel);
      I_memE = 1; I_memWe = 0; I_address = addr; I_selMem = sel; I_we = 1;
      I_storeData = $urandom;
      set_common();
      if (!mis) push_wb(1, ref_load(addr, sel), WAIT + 2);
      for (int c = 0; c < WAIT + 2; c++) begin
         #1 chk("busy_load", 32'(O_busy), 32'(c <= WAIT));
`ifdef CEESPU_MISALIGN_TRAP_EN
         if (c == 1) chk("misaligned_load", 32'(O_misaligned), 32'(mis));
`endif
         step();
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a = $urandom;
      return a;
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      repeat (3) step();
      chk("rst_busy", 32'(O_busy), 32'd0);
      chk("rst_we", 32'(O_we), 32'd0);
      chk("rst_loadData", O_loadData, 32'd0);
      chk("rst_alu", O_aluResult, 32'd0);
      chk("rst_regD", 32'(O_regD), 32'd0);
      chk("rst_selWb", 32'(O_selWb), 32'd0);
      I_rst = 0;
      step();
      for (int w = 0; w < NW; w++) do_store(32'(w * 4), 3'b000, 4'b1111, $urandom);

      do_store(32'h10, 3'b000, 4'b1111, 32'hDEADBEEF);
      do_load(32'h10, 3'b000);
      do_store(32'h22, 3'b010, 4'b0100, 32'h80808080);
      do_load(32'h22, 3'b010);
      do_load(32'h22, 3'b110);
      do_load(32'h20, 3'b000);
      do_store(32'h31, 3'b001, 4'b1100, 32'h12341234);
      do_load(32'h31, 3'b001);
      do_load(32'h30, 3'b101);
      do_load(32'h30, 3'b001);
      nop(1);
      nop(0);
      nop(0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      I_memE = 1; I_memWe = 0; I_address = 32'h10; I_selMem = 0; I_we = 1;
      set_common();
      step();
      I_rst = 1;
      #1 chk("rst_mid_busy", 32'(O_busy), 32'd0);
      chk("rst_mid_we", 32'(O_we), 32'd0);
      chk("rst_mid_loadData", O_loadData, 32'd0);
      chk("rst_mid_alu", O_aluResult, 32'd0);
      chk("rst_mid_regD", 32'(O_regD), 32'd0);
      I_memE = 0; I_we = 0;
      step();
      step();
      I_rst = 0;
      repeat (WAIT + 4) nop(0);
      do_load(32'h10, 3'b000);

`ifdef CEESPU_MISALIGN_TRAP_EN
      do_store(32'h42, 3'b000, 4'b1111, 32'hCAFEF00D);
      nop(0);
      do_load(32'h40, 3'b000);
      do_load(32'h41, 3'b000);
`endif

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 2))
            0: nop(1'($urandom));
            1: rand_store(rand_addr());
            default: do_load(rand_addr(), 3'($urandom));
         endcase
      end
      repeat (WAIT + 3) nop(0);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
